// File: rtl/ps2_mouse_packet_assembler.sv
// PS/2 mouse packet assembler: enables data reporting on the device, waits
// for its acknowledge, then frames the byte stream into 3-byte movement
// packets and presents decoded fields with a one-cycle valid strobe.
module ps2_mouse_packet_assembler #(
  parameter int unsigned TIMEOUT_CYCLES     = 2_000_000,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0]  CMD_ENABLE         = 8'hF4,
  parameter logic [7:0]  ACK_BYTE           = 8'hFA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_req,
  output logic       init_done,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic       o_x_sign,
  output logic       o_y_sign,
  output logic       o_x_ov,
  output logic       o_y_ov,
  output logic       o_l_click,
  output logic       o_r_click,
  output logic       o_valid
);

  // One shared timer serves both the ACK wait and the inter-byte gap.
  localparam int unsigned MAX_T = (TIMEOUT_CYCLES > ACK_TIMEOUT_CYCLES) ?
                                  TIMEOUT_CYCLES : ACK_TIMEOUT_CYCLES;
  localparam int TMR_W = $clog2(MAX_T + 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    SEND_EN, WAIT_TX, WAIT_ACK, B0, B1, B2
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  // Header flags kept as {y_ov, x_ov, y_sign, x_sign, r_click, l_click}.
  logic [5:0]       hdr_q, hdr_d;
  logic [7:0]       byte1_q, byte1_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_req_q, tx_req_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       o_x_q, o_x_d;
  logic [7:0]       o_y_q, o_y_d;
  logic [5:0]       flags_q, flags_d;
  logic             o_valid_q, o_valid_d;

  // Next-state logic: init handshake, packet framing and timeouts.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    hdr_d       = hdr_q;
    byte1_d     = byte1_q;
    tx_data_d   = tx_data_q;
    tx_req_d    = 1'b0;
    init_done_d = init_done_q;
    o_x_d       = o_x_q;
    o_y_d       = o_y_q;
    flags_d     = flags_q;
    o_valid_d   = 1'b0;
    case (state_q)
      SEND_EN: begin
        timer_d = '0;
        if (!tx_busy) begin
          tx_req_d  = 1'b1;
          tx_data_d = CMD_ENABLE;
          state_d   = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          tx_data_d = '0;
          timer_d   = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // The byte is evaluated before the retry timeout.
        if (rx_valid && rx_data == ACK_BYTE) begin
          init_done_d = 1'b1;
          timer_d     = '0;
          state_d     = B0;
        end else if (timer_q >= ACK_LAST) begin
          timer_d = '0;
          state_d = SEND_EN;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      B0: begin
        // Only a byte with bit3 set can start a packet; others resync.
        timer_d = '0;
        if (rx_valid && rx_data[3]) begin
          hdr_d   = {rx_data[7:4], rx_data[1:0]};
          state_d = B1;
        end
      end
      B1: begin
        if (rx_valid) begin
          byte1_d = rx_data;
          timer_d = '0;
          state_d = B2;
        end else if (rx_err || timer_q >= TO_LAST) begin
          timer_d = '0;
          state_d = B0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      B2: begin
        if (rx_valid) begin
          o_x_d     = byte1_q;
          o_y_d     = rx_data;
          flags_d   = hdr_q;
          o_valid_d = 1'b1;
          timer_d   = '0;
          state_d   = B0;
        end else if (rx_err || timer_q >= TO_LAST) begin
          timer_d = '0;
          state_d = B0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = SEND_EN;
    endcase
  end

  // State and output registers; reset restarts the init handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEND_EN;
      timer_q     <= '0;
      hdr_q       <= '0;
      byte1_q     <= '0;
      tx_data_q   <= '0;
      tx_req_q    <= 1'b0;
      init_done_q <= 1'b0;
      o_x_q       <= '0;
      o_y_q       <= '0;
      flags_q     <= '0;
      o_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      hdr_q       <= hdr_d;
      byte1_q     <= byte1_d;
      tx_data_q   <= tx_data_d;
      tx_req_q    <= tx_req_d;
      init_done_q <= init_done_d;
      o_x_q       <= o_x_d;
      o_y_q       <= o_y_d;
      flags_q     <= flags_d;
      o_valid_q   <= o_valid_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_req    = tx_req_q;
  assign init_done = init_done_q;
  assign o_x       = o_x_q;
  assign o_y       = o_y_q;
  assign o_y_ov    = flags_q[5];
  assign o_x_ov    = flags_q[4];
  assign o_y_sign  = flags_q[3];
  assign o_x_sign  = flags_q[2];
  assign o_r_click = flags_q[1];
  assign o_l_click = flags_q[0];
  assign o_valid   = o_valid_q;

endmodule

// File: tb/tb_ps2_mouse_packet_assembler.sv
// Bench for ps2_mouse_packet_assembler: table of packets with expected
// decoded fields, scoreboard queue popped on each o_valid, plus sequences
// for init, retry, timeout, receive error and reset.
module tb_ps2_mouse_packet_assembler;

  localparam int unsigned TO  = 40;
  localparam int unsigned ATO = 80;
  localparam logic [7:0]  CMD = 8'hF4;
  localparam logic [7:0]  ACK = 8'hFA;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, tx_busy, tx_done;
  logic [7:0] tx_data;
  logic       tx_req, init_done;
  logic [7:0] o_x, o_y;
  logic       o_x_sign, o_y_sign, o_x_ov, o_y_ov, o_l_click, o_r_click, o_valid;

  always #5 clk = ~clk;

  ps2_mouse_packet_assembler #(
    .TIMEOUT_CYCLES(TO), .ACK_TIMEOUT_CYCLES(ATO),
    .CMD_ENABLE(CMD), .ACK_BYTE(ACK)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_data(tx_data), .tx_req(tx_req), .init_done(init_done),
    .o_x(o_x), .o_y(o_y), .o_x_sign(o_x_sign), .o_y_sign(o_y_sign),
    .o_x_ov(o_x_ov), .o_y_ov(o_y_ov), .o_l_click(o_l_click),
    .o_r_click(o_r_click), .o_valid(o_valid)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic xs, ys, xov, yov, l, r;
  } exp_t;

  typedef struct {
    logic [7:0] b0, b1, b2;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_txreq = 0;

  function automatic exp_t cur_out();
    return {o_x, o_y, o_x_sign, o_y_sign, o_x_ov, o_y_ov, o_l_click, o_r_click};
  endfunction

  function automatic exp_t mk(input logic [7:0] x, input logic [7:0] y,
                              input logic xs, input logic ys, input logic xov,
                              input logic yov, input logic l, input logic r);
    return {x, y, xs, ys, xov, yov, l, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock; sample just after the edge and score any emitted packet.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (tx_req) begin
      n_txreq++;
      chk("tx_data_on_req", 32'(tx_data), 32'(CMD));
    end
    if (o_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_o_valid", 32'(1), 32'(0));
      end else begin
        e = sbq.pop_front();
        chk("pkt_fields", 32'(cur_out()), 32'(e));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx"}, 32'({tx_data, tx_req, init_done}), 32'(0));
    chk({tag, "_fields"}, 32'(cur_out()), 32'(0));
    chk({tag, "_valid"}, 32'(o_valid), 32'(0));
  endtask

  vec_t tbl[5];
  exp_t last;

  initial begin
    tbl[0] = '{8'h09, 8'h05, 8'hFB, mk(8'h05, 8'hFB, 0, 0, 0, 0, 1, 0)};
    tbl[1] = '{8'hD8, 8'h10, 8'h20, mk(8'h10, 8'h20, 1, 0, 1, 1, 0, 0)};
    tbl[2] = '{8'h2A, 8'h7F, 8'h01, mk(8'h7F, 8'h01, 0, 1, 0, 0, 0, 1)};
    tbl[3] = '{8'h0C, 8'h00, 8'h00, mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)};
    tbl[4] = '{8'h3B, 8'hFF, 8'h80, mk(8'hFF, 8'h80, 1, 1, 0, 0, 1, 1)};

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0;
    idle(3);
    check_all_zero("reset");

    // Init handshake.
    rst = 1'b0;
    n_txreq = 0;
    idle(10);
    chk("init_txreq_count", 32'(n_txreq), 32'(1));
    chk("tx_data_held", 32'(tx_data), 32'(CMD));
    send_byte(ACK);
    chk("ack_in_wait_tx_ignored", 32'(init_done), 32'(0));
    pulse_done();
    send_byte(8'h00);
    chk("non_ack_ignored", 32'(init_done), 32'(0));
    send_byte(ACK);
    chk("init_done", 32'(init_done), 32'(1));
    chk("fields_after_init", 32'(cur_out()), 32'(0));

    // Resync bytes, then back-to-back packets with no idle cycles.
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      sbq.push_back(tbl[i].e);
      send_byte(tbl[i].b0);
      send_byte(tbl[i].b1);
      send_byte(tbl[i].b2);
    end
    idle(2);
    chk("table_drained", 32'(sbq.size()), 32'(0));
    chk("hold_after_idle", 32'(cur_out()), 32'(tbl[4].e));

    // Inter-byte timeout drops the partial packet.
    send_byte(8'h08);
    send_byte(8'h03);
    idle(TO + 5);
    chk("hold_after_timeout", 32'(cur_out()), 32'(tbl[4].e));
    sbq.push_back(mk(8'h01, 8'h02, 0, 0, 0, 0, 0, 1));
    send_byte(8'h0A);
    send_byte(8'h01);
    send_byte(8'h02);
    idle(1);
    chk("drained_after_timeout", 32'(sbq.size()), 32'(0));

    // Gaps comfortably inside the timeout keep the packet.
    last = mk(8'h21, 8'h31, 0, 0, 0, 0, 0, 0);
    sbq.push_back(last);
    send_byte(8'h08);
    idle(TO - 2);
    send_byte(8'h21);
    idle(TO - 2);
    send_byte(8'h31);
    idle(1);
    chk("drained_slow_packet", 32'(sbq.size()), 32'(0));

    // Receive error after byte1 drops the packet; next packet resyncs.
    send_byte(8'h1B);
    send_byte(8'h44);
    rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    send_byte(8'h55);
    idle(3);
    chk("hold_after_rx_err", 32'(cur_out()), 32'(last));
    sbq.push_back(mk(8'h11, 8'h22, 0, 0, 0, 0, 1, 0));
    send_byte(8'h09);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(1);
    chk("drained_after_rx_err", 32'(sbq.size()), 32'(0));

    // Reset while waiting for the third byte.
    send_byte(8'h08);
    send_byte(8'h33);
    rst = 1'b1;
    #1;
    check_all_zero("mid_packet_reset");
    idle(3);
    rst = 1'b0;
    n_txreq = 0;
    idle(10);
    chk("reinit_txreq_count", 32'(n_txreq), 32'(1));
    chk("reinit_not_done", 32'(init_done), 32'(0));

    // Wrong byte then ACK timeout forces a resend of the enable command.
    pulse_done();
    send_byte(8'hFE);
    n_txreq = 0;
    idle(ATO + 10);
    chk("ack_retry_txreq", 32'(n_txreq), 32'(1));
    chk("ack_retry_not_done", 32'(init_done), 32'(0));
    pulse_done();
    send_byte(ACK);
    chk("init_after_retry", 32'(init_done), 32'(1));

    sbq.push_back(mk(8'h80, 8'h7E, 1, 1, 1, 0, 0, 1));
    send_byte(8'h7A);
    send_byte(8'h80);
    send_byte(8'h7E);
    idle(2);
    chk("final_drained", 32'(sbq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_assembler.md
Name: ps2_mouse_packet_assembler

Overview:
- Sits between the PS/2 byte-level receiver/transmitter and the mouse interface top.
- After reset it sends the Enable Data Reporting command (0xF4) and waits for the device ACK (0xFA).
- It then groups the incoming byte stream into 3-byte movement packets and decodes them into the x/y/sign/overflow/click fields, plus a one-cycle valid strobe, that the mouse position/click logic consumes.
- Handles resynchronisation, inter-byte timeout and receive errors.

Parameters:
- TIMEOUT_CYCLES, 2_000_000, maximum clk cycles allowed between bytes of one packet (20 ms at 100 MHz).
- ACK_TIMEOUT_CYCLES, 10_000_000, maximum clk cycles to wait for 0xFA before resending 0xF4 (100 ms at 100 MHz).
- CMD_ENABLE, 8'hF4, command byte sent at init.
- ACK_BYTE, 8'hFA, expected acknowledge byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- rx_err  in  1  one-cycle strobe: parity/framing error on the current byte (rx_valid not asserted with it)
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle strobe: command byte fully sent
- tx_data  out  8  command byte to transmit
- tx_req  out  1  one-cycle transmit request
- init_done  out  1  high once ACK received; stays high until reset
- o_x  out  8  X movement magnitude byte
- o_y  out  8  Y movement magnitude byte
- o_x_sign  out  1  byte0 bit4
- o_y_sign  out  1  byte0 bit5
- o_x_ov  out  1  byte0 bit6
- o_y_ov  out  1  byte0 bit7
- o_l_click  out  1  byte0 bit0
- o_r_click  out  1  byte0 bit1
- o_valid  out  1  one-cycle strobe: new packet on outputs

Behaviour:
- Reset (async, rst=1):
  - State SEND_EN; all outputs 0, including tx_data, tx_req, init_done and every o_* signal.
  - Internal byte latches and timers are cleared.
  - Reset mid-packet or mid-init discards everything and restarts init.
- States: SEND_EN, WAIT_TX, WAIT_ACK, B0, B1, B2.
- SEND_EN:
  - When tx_busy=0: tx_req=1 for exactly one cycle with tx_data=CMD_ENABLE, then go to WAIT_TX.
  - tx_data holds CMD_ENABLE until tx_done.
- WAIT_TX: on tx_done go to WAIT_ACK and clear the ACK timer.
- WAIT_ACK:
  - rx_valid with rx_data==ACK_BYTE: init_done<=1, go to B0.
  - Any other byte, or rx_err: ignored, keep waiting; the timer is not cleared.
  - Timer reaches ACK_TIMEOUT_CYCLES: go to SEND_EN (retry indefinitely).
- rx_valid in SEND_EN or WAIT_TX is ignored.
- B0, on rx_valid:
  - rx_data[3]==1: latch as byte0, go to B1.
  - rx_data[3]==0: discard, stay in B0 (resync). No timeout applies in B0.
- B1, on rx_valid: latch as byte1 (X), go to B2.
- B2, on rx_valid: go to B0 and, on the same edge, register all outputs:
  - o_x <= byte1, o_y <= rx_data.
  - Flags from byte0 per the bit mapping in Ports.
  - o_valid <= 1.
- Latency: o_valid and the new field values appear on the clock edge that samples the third byte's rx_valid. The strobe is visible during the following cycle only. o_valid=0 at all other times.
- Output hold: o_* fields keep the last packet's values between packets. Aborted packets never change them.
- Inter-byte timer (B1/B2):
  - Counts clk cycles; cleared on every accepted rx_valid.
  - Reaching TIMEOUT_CYCLES with no byte: discard the partial packet, go to B0.
  - Timer width is sized to hold the larger of the two timeout parameters.
- rx_err in B0/B1/B2: discard the partial packet, go to B0, no o_valid.
- Simultaneous events:
  - rx_valid in the same cycle the timer expires: the byte is accepted and the timeout is ignored.
  - rx_valid and ACK-timer expiry in the same cycle in WAIT_ACK: the byte is evaluated first. If it is 0xFA, init succeeds.
- Back-to-back: a new byte0 accepted in the cycle after o_valid is legal. Packets arriving one per 3 rx_valid strobes with zero idle cycles must all be emitted.
- Once init_done=1, the block never returns to the init states except via reset.

Test Plan:
- Reset release, tx_busy=0 -> tx_req pulses once with tx_data=8'hF4. Then tx_done, then rx 8'hFA -> init_done=1, all o_* still 0.
- After init, send bytes 8'h09, 8'h05, 8'hFB -> o_valid pulses once. o_l_click=1, o_r_click=0, o_x=8'h05, o_y=8'hFB, o_x_sign=0, o_y_sign=0, o_x_ov=0, o_y_ov=0.
- Send 8'h01 (bit3=0), then 8'hD8, 8'h10, 8'h20 -> 8'h01 discarded. Outputs: o_x=8'h10, o_y=8'h20, o_x_sign=1, o_y_sign=0, o_x_ov=1, o_y_ov=1, o_l_click=0, o_r_click=0, one o_valid.
- Send 8'h08, 8'h03, then idle TIMEOUT_CYCLES. Then 8'h0A, 8'h01, 8'h02 -> first packet dropped without o_valid; second yields o_r_click=1, o_x=1, o_y=2. Also repeat with rx_err after byte1 -> partial packet dropped, outputs unchanged.
- In WAIT_ACK, send 8'hFE and wait ACK_TIMEOUT_CYCLES -> second tx_req with 8'hF4; then 8'hFA -> init_done=1.
- Assert rst while in B2 -> all outputs 0 immediately, no o_valid. On release the block re-issues 8'hF4.
